// File: rtl/bcd_event_counter_if.sv
// Bus bundle for bcd_event_counter.
// Purpose: groups the count-control inputs and the registered count/pulse
// outputs so the counter and its user connect through one port.
// Signals:
//   en          count event, one step per clk while high
//   up_dn       1 = count up, 0 = count down
//   load        synchronous load of load_val
//   load_val    packed digits to load, digit 0 in [3:0]
//   clr         synchronous clear of count and wrap_flag
//   count       registered packed digit values, digit 0 in [3:0]
//   digit_carry one-cycle pulse per digit on that digit's wrap
//   tc_pulse    one-cycle pulse when the whole chain wraps
//   wrap_flag   sticky flag set with tc_pulse
// Modports: master drives the controls, slave is the counter.
interface bcd_event_counter_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up_dn;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  clr;
  logic [4*DIGITS-1:0]   count;
  logic [DIGITS-1:0]     digit_carry;
  logic                  tc_pulse;
  logic                  wrap_flag;

  modport master (
    output en, up_dn, load, load_val, clr,
    input  count, digit_carry, tc_pulse, wrap_flag
  );

  modport slave (
    input  en, up_dn, load, load_val, clr,
    output count, digit_carry, tc_pulse, wrap_flag
  );
endinterface

// File: rtl/bcd_event_counter.sv
// bcd_event_counter: cascaded multi-digit event counter, RADIX per digit.
// Purpose: counts events up or down across DIGITS 4-bit digits, with
// synchronous load/clear, per-digit carry pulses, a whole-chain terminal
// pulse and a sticky wrap flag. Feeds the digit-to-segment/LCD encoder.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-low reset
//   bus  bcd_event_counter_if.slave (controls in, count/pulses out)
// Priority at each edge: rst > clr > load > en.
// Optional build macro BCD_CNT_SATURATE_EN: when defined, an up event at
// all-max or a down event at all-zero holds the count (no digit_carry) but
// still pulses tc_pulse and sets wrap_flag. Default build wraps.
module bcd_event_counter #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_event_counter_if.slave   bus
);

  localparam int         W    = 4 * DIGITS;
  localparam logic [3:0] DMAX = 4'(RADIX - 1);
  localparam logic [3:0] DILL = 4'(RADIX - 2);

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > DMAX) ? DMAX : d;
  endfunction

  function automatic logic [W-1:0] clamp_all(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = clamp_digit(v[4*k +: 4]);
    end
    return r;
  endfunction

  logic [W-1:0]      count_p1;
  logic [DIGITS-1:0] dc_p1;
  logic              tc_p1;
  logic              wf_p1;

  logic [W-1:0]      stepped;
  logic [DIGITS-1:0] wrapped;
  logic              ripple;
  logic [3:0]        d_cur;
  logic              full_wrap;

  logic [W-1:0]      count_n;
  logic [DIGITS-1:0] dc_n;
  logic              tc_n;
  logic              wf_n;

  // Ripple one step through the chain. ripple stays high only while every
  // lower digit wrapped, so digit k moves only behind a full lower wrap.
  always_comb begin
    stepped = count_p1;
    wrapped = '0;
    ripple  = 1'b1;
    d_cur   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d_cur = count_p1[4*k +: 4];
      if (ripple) begin
        if (bus.up_dn) begin
          if (d_cur >= DMAX) begin
            // Illegal digits above DMAX also wrap to zero on the way up.
            stepped[4*k +: 4] = 4'd0;
            wrapped[k]        = 1'b1;
          end else begin
            stepped[4*k +: 4] = d_cur + 4'd1;
            ripple            = 1'b0;
          end
        end else begin
          if (d_cur == 4'd0) begin
            stepped[4*k +: 4] = DMAX;
            wrapped[k]        = 1'b1;
          end else if (d_cur > DMAX) begin
            stepped[4*k +: 4] = DILL;
            ripple            = 1'b0;
          end else begin
            stepped[4*k +: 4] = d_cur - 4'd1;
            ripple            = 1'b0;
          end
        end
      end
    end
    full_wrap = wrapped[DIGITS-1];
  end

  always_comb begin
    count_n = count_p1;
    dc_n    = '0;
    tc_n    = 1'b0;
    wf_n    = wf_p1;
    if (!rst) begin
      count_n = '0;
      wf_n    = 1'b0;
    end else if (bus.clr) begin
      count_n = '0;
      wf_n    = 1'b0;
    end else if (bus.load) begin
      count_n = clamp_all(bus.load_val);
    end else if (bus.en) begin
`ifdef BCD_CNT_SATURATE_EN
      if (full_wrap) begin
        tc_n = 1'b1;
        wf_n = 1'b1;
      end else begin
        count_n = stepped;
        dc_n    = wrapped;
      end
`else
      count_n = stepped;
      dc_n    = wrapped;
      tc_n    = full_wrap;
      if (full_wrap) begin
        wf_n = 1'b1;
      end
`endif
    end
  end

  // Stage p1: all outputs registered, one clk after the sampled inputs.
  always_ff @(posedge clk) begin
    count_p1 <= count_n;
    dc_p1    <= dc_n;
    tc_p1    <= tc_n;
    wf_p1    <= wf_n;
  end

  assign bus.count       = count_p1;
  assign bus.digit_carry = dc_p1;
  assign bus.tc_pulse    = tc_p1;
  assign bus.wrap_flag   = wf_p1;

endmodule
